// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port between N valid/ready producers.
// Each grant covers a burst of up to MAX_BURST beats and stalls on fifo_full without rotating.
module fifo_wr_arbiter #(
   parameter int N         = 4,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req_valid,
   input  logic [N*DW-1:0]      req_data,
   output logic [N-1:0]         req_ready,
   input  logic                 fifo_full,
   output logic                 fifo_wr_en,
   output logic [DW-1:0]        fifo_wr_data,
   output logic [$clog2(N)-1:0] grant_id,
   output logic                 busy
);

   localparam int IW = $clog2(N);
   localparam int BW = $clog2(MAX_BURST) + 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
   localparam logic [IW-1:0] TOP_ID    = IW'(N - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   last_id, last_id_nxt;
   logic [IW-1:0]   grant_nxt;
   logic [BW-1:0]   beat_cnt, beat_nxt;
   logic [IW-1:0]   rr_pick;
   logic [IW-1:0]   rr_cand;
   logic            rr_found;
   logic            xfer;
   logic [DW-1:0]   data_arr [N];

   always_comb begin
      for (int k = 0; k < N; k++) begin
         data_arr[k] = req_data[k*DW +: DW];
      end
   end

   // Scan starts just after the previous holder so it competes again only last.
   always_comb begin
      rr_pick  = '0;
      rr_found = 1'b0;
      rr_cand  = last_id;
      for (int i = 0; i < N; i++) begin
         rr_cand = (rr_cand == TOP_ID) ? '0 : rr_cand + 1'b1;
         if (!rr_found && req_valid[rr_cand]) begin
            rr_found = 1'b1;
            rr_pick  = rr_cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == GRANT) begin
         req_ready[grant_id] = !fifo_full;
      end
   end

   assign xfer         = (state == GRANT) && req_valid[grant_id] && !fifo_full;
   assign fifo_wr_en   = xfer;
   assign fifo_wr_data = xfer ? data_arr[grant_id] : '0;
   assign busy         = (state == GRANT);

   // A full FIFO freezes the burst; only a final beat or a dropped valid ends it.
   always_comb begin
      state_nxt   = state;
      grant_nxt   = grant_id;
      last_id_nxt = last_id;
      beat_nxt    = beat_cnt;
      unique case (state)
         IDLE: begin
            if (rr_found) begin
               state_nxt = GRANT;
               grant_nxt = rr_pick;
               beat_nxt  = '0;
            end
         end
         GRANT: begin
            if (xfer) begin
               beat_nxt = beat_cnt + 1'b1;
               if (beat_cnt == LAST_BEAT) begin
                  state_nxt   = IDLE;
                  last_id_nxt = grant_id;
               end
            end else if (!req_valid[grant_id]) begin
               state_nxt   = IDLE;
               last_id_nxt = grant_id;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant_id <= '0;
         last_id  <= TOP_ID;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         grant_id <= grant_nxt;
         last_id  <= last_id_nxt;
         beat_cnt <= beat_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: queue-based producers and a 16-deep FIFO model
// surround the DUT; each scenario task checks its own hand-derived expectations.
module tb_fifo_wr_arbiter;

   localparam int N         = 4;
   localparam int DW        = 8;
   localparam int MAX_BURST = 4;
   localparam int DEPTH     = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            fifo_full;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_wr_data;
   logic [1:0]      grant_id;
   logic            busy;

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0] pq [N][$];
   logic [DW-1:0] fq [$];
   bit            wen_q [$];
   logic [1:0]    gid_q [$];
   bit            busy_q [$];
   logic [N-1:0]  rdy_q [$];

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .grant_id     (grant_id),
      .busy         (busy)
   );

   task automatic clear_logs();
      wen_q.delete();
      gid_q.delete();
      busy_q.delete();
      rdy_q.delete();
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      for (int k = 0; k < N; k++) pq[k].delete();
      fq.delete();
      clear_logs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One clock: drive producers/full from the models, sample, then commit the edge.
   task automatic cycle(input bit do_read);
      logic [N-1:0]  acc;
      bit            wr;
      logic [DW-1:0] wd;
      for (int k = 0; k < N; k++) begin
         req_valid[k]         = (pq[k].size() > 0);
         req_data[k*DW +: DW] = (pq[k].size() > 0) ? pq[k][0] : '0;
      end
      fifo_full = (fq.size() >= DEPTH);
      #1;
      acc = req_valid & req_ready;
      wr  = fifo_wr_en;
      wd  = fifo_wr_data;
      wen_q.push_back(wr);
      gid_q.push_back(grant_id);
      busy_q.push_back(busy);
      rdy_q.push_back(req_ready);
      vectors++;
      if (wr && fifo_full) begin
         miscompares++;
         $display("[TB] FAIL write_while_full: wr_en=%0b full=%0b required wr_en=0", wr, fifo_full);
      end
      @(posedge clk);
      for (int k = 0; k < N; k++) if (acc[k]) void'(pq[k].pop_front());
      if (wr) fq.push_back(wd);
      if (do_read && fq.size() > 0) void'(fq.pop_front());
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '1;
      req_data  = '1;
      fifo_full = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++; $display("[TB] FAIL reset_busy: got %0b required 0", busy);
      end
      vectors++;
      if (req_ready !== 4'b0000) begin
         miscompares++; $display("[TB] FAIL reset_ready: got %b required 0000", req_ready);
      end
      vectors++;
      if (fifo_wr_en !== 1'b0) begin
         miscompares++; $display("[TB] FAIL reset_wr_en: got %0b required 0", fifo_wr_en);
      end
      vectors++;
      if (fifo_wr_data !== 8'h00) begin
         miscompares++; $display("[TB] FAIL reset_wr_data: got %0h required 00", fifo_wr_data);
      end
      vectors++;
      if (grant_id !== 2'd0) begin
         miscompares++; $display("[TB] FAIL reset_grant_id: got %0d required 0", grant_id);
      end
   endtask

   task automatic test_single();
      logic [9:0] exp_wen;
      do_reset();
      for (int i = 0; i < 6; i++) pq[2].push_back(8'h10 + 8'(i));
      exp_wen = 10'b0011011110;
      repeat (10) cycle(0);
      vectors++;
      if (gid_q[1] !== 2'd2) begin
         miscompares++; $display("[TB] FAIL single_grant: got %0d required 2", gid_q[1]);
      end
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if (wen_q[i] !== exp_wen[i]) begin
            miscompares++;
            $display("[TB] FAIL single_wen[%0d]: got %0b required %0b", i, wen_q[i], exp_wen[i]);
         end
      end
      vectors++;
      if (fq.size() !== 6) begin
         miscompares++; $display("[TB] FAIL single_count: got %0d required 6", fq.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            vectors++;
            if (fq[i] !== 8'h10 + 8'(i)) begin
               miscompares++;
               $display("[TB] FAIL single_data[%0d]: got %0h required %0h", i, fq[i], 8'h10 + 8'(i));
            end
         end
      end
   endtask

   task automatic test_all_four();
      logic [7:0] exp_d;
      do_reset();
      for (int k = 0; k < N; k++)
         for (int m = 0; m < 8; m++) pq[k].push_back(8'((k << 4) | m));
      repeat (22) cycle(0);
      for (int j = 0; j < 5; j++) begin
         vectors++;
         if (gid_q[1 + 5*j] !== 2'(j % 4)) begin
            miscompares++;
            $display("[TB] FAIL rr_grant[%0d]: got %0d required %0d", j, gid_q[1 + 5*j], j % 4);
         end
      end
      for (int i = 0; i < 21; i++) begin
         vectors++;
         if (wen_q[i] !== (i % 5 != 0)) begin
            miscompares++;
            $display("[TB] FAIL rr_wen[%0d]: got %0b required %0b", i, wen_q[i], (i % 5 != 0));
         end
      end
      for (int i = 0; i < 16; i++) begin
         exp_d = 8'(((i / 4) << 4) | (i % 4));
         vectors++;
         if (fq[i] !== exp_d) begin
            miscompares++; $display("[TB] FAIL rr_data[%0d]: got %0h required %0h", i, fq[i], exp_d);
         end
      end
   endtask

   task automatic test_back_pressure();
      logic [N-1:0] r;
      do_reset();
      for (int i = 0; i < 15; i++) fq.push_back(8'hE0 + 8'(i));
      pq[1].push_back(8'hA0);
      pq[1].push_back(8'hA1);
      pq[1].push_back(8'hA2);
      repeat (7) cycle(0);
      cycle(1);
      cycle(1);
      repeat (3) cycle(0);
      vectors++;
      if (rdy_q[1] !== 4'b0010) begin
         miscompares++; $display("[TB] FAIL bp_first_ready: got %b required 0010", rdy_q[1]);
      end
      vectors++;
      if (wen_q[1] !== 1'b1) begin
         miscompares++; $display("[TB] FAIL bp_first_write: got %0b required 1", wen_q[1]);
      end
      for (int i = 2; i < 7; i++) begin
         r = rdy_q[i];
         vectors++;
         if (r[1] !== 1'b0 || wen_q[i] !== 1'b0 || gid_q[i] !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL bp_stall[%0d]: ready=%b wr_en=%0b grant=%0d required ready=0000 wr_en=0 grant=1",
                     i, r, wen_q[i], gid_q[i]);
         end
      end
      vectors++;
      if (wen_q[8] !== 1'b1 || wen_q[9] !== 1'b1) begin
         miscompares++; $display("[TB] FAIL bp_resume: got %0b%0b required 11", wen_q[8], wen_q[9]);
      end
      vectors++;
      if (fq.size() !== 16) begin
         miscompares++; $display("[TB] FAIL bp_count: got %0d required 16", fq.size());
      end else begin
         vectors++;
         if (fq[0] !== 8'hE2 || fq[13] !== 8'hA0 || fq[14] !== 8'hA1 || fq[15] !== 8'hA2) begin
            miscompares++;
            $display("[TB] FAIL bp_data: got %0h %0h %0h %0h required e2 a0 a1 a2",
                     fq[0], fq[13], fq[14], fq[15]);
         end
      end
      vectors++;
      if (busy_q[11] !== 1'b0) begin
         miscompares++; $display("[TB] FAIL bp_release: busy got %0b required 0", busy_q[11]);
      end
   endtask

   task automatic test_early_release();
      bit exp_wen [6];
      exp_wen = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      do_reset();
      pq[0].push_back(8'h50);
      pq[0].push_back(8'h51);
      pq[3].push_back(8'h70);
      pq[3].push_back(8'h71);
      repeat (4) cycle(0);
      pq[0].push_back(8'h52);
      repeat (2) cycle(0);
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (wen_q[i] !== exp_wen[i]) begin
            miscompares++;
            $display("[TB] FAIL early_wen[%0d]: got %0b required %0b", i, wen_q[i], exp_wen[i]);
         end
      end
      vectors++;
      if (busy_q[3] !== 1'b1 || busy_q[4] !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL early_busy: got %0b%0b required 10", busy_q[3], busy_q[4]);
      end
      vectors++;
      if (gid_q[5] !== 2'd3) begin
         miscompares++; $display("[TB] FAIL early_next_grant: got %0d required 3", gid_q[5]);
      end
      vectors++;
      if (fq.size() !== 3 || fq[2] !== 8'h70) begin
         miscompares++;
         $display("[TB] FAIL early_data: size %0d last %0h required size 3 last 70", fq.size(), fq[fq.size()-1]);
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      for (int i = 0; i < 6; i++) pq[2].push_back(8'hC0 + 8'(i));
      repeat (3) cycle(0);
      rst_n = 1'b0;
      #1;
      vectors++;
      if (req_ready !== 4'b0000 || fifo_wr_en !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midreset_outputs: ready=%b wr_en=%0b busy=%0b required 0000 0 0",
                  req_ready, fifo_wr_en, busy);
      end
      pq[1].push_back(8'hB0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      clear_logs();
      repeat (2) cycle(0);
      vectors++;
      if (gid_q[1] !== 2'd1) begin
         miscompares++; $display("[TB] FAIL midreset_grant: got %0d required 1", gid_q[1]);
      end
      vectors++;
      if (fq.size() !== 3 || fq[0] !== 8'hC0 || fq[1] !== 8'hC1 || fq[2] !== 8'hB0) begin
         miscompares++;
         $display("[TB] FAIL midreset_data: size %0d required 3 entries c0 c1 b0", fq.size());
      end
   endtask

   task automatic test_idle();
      do_reset();
      pq[2].push_back(8'h33);
      repeat (24) cycle(0);
      vectors++;
      if (gid_q[1] !== 2'd2 || wen_q[1] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL idle_setup: grant %0d wr_en %0b required 2 1", gid_q[1], wen_q[1]);
      end
      for (int i = 4; i < 24; i++) begin
         vectors++;
         if (busy_q[i] !== 1'b0 || wen_q[i] !== 1'b0 || gid_q[i] !== 2'd2) begin
            miscompares++;
            $display("[TB] FAIL idle[%0d]: busy=%0b wr_en=%0b grant=%0d required 0 0 2",
                     i, busy_q[i], wen_q[i], gid_q[i]);
         end
      end
   endtask

   initial begin
      $display("[TB] starting fifo_wr_arbiter bench");
      test_reset();
      test_single();
      test_all_four();
      test_back_pressure();
      test_early_release();
      test_reset_mid_burst();
      test_idle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the write port of one `sync_fifo` between N independent producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst, then passes the FIFO's `wr_en`/`wr_data` through and back-pressures on `full`. It sits directly in front of the FIFO write side; the read side is untouched.

## Interface
- `N`, 4: number of requesters (2..8).
- `DW`, 8: data width; must match the FIFO `DW`.
- `MAX_BURST`, 4: maximum beats per grant (1..16).

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N  per-requester data valid.
- `req_data`  in  N*DW  packed data; requester k occupies bits [k*DW +: DW].
- `req_ready`  out  N  per-requester ready; combinational.
- `fifo_full`  in  1  FIFO `full` flag.
- `fifo_wr_en`  out  1  FIFO write enable; combinational.
- `fifo_wr_data`  out  DW  FIFO write data; combinational mux of the granted requester.
- `grant_id`  out  $clog2(N)  index of the current grant holder; registered.
- `busy`  out  1  high in GRANT state; registered.

## Operation
- Two-state FSM: IDLE and GRANT. Registered state: `grant_id`, `last_id`, `beat_cnt` ($clog2(MAX_BURST)+1 bits).
- Reset values:
  - state = IDLE, `grant_id` = 0, `last_id` = N-1, `beat_cnt` = 0.
  - Outputs: `busy` = 0, `req_ready` = 0, `fifo_wr_en` = 0, `fifo_wr_data` = 0.
- IDLE:
  - If any `req_valid` is set, select the first valid index scanning `last_id`+1, `last_id`+2, …, wrapping modulo N.
  - Load `grant_id` with that index, clear `beat_cnt`, go to GRANT.
  - If no `req_valid` is set, stay in IDLE.
- GRANT:
  - `req_ready[grant_id]` = !`fifo_full`; all other `req_ready` bits are 0.
  - Transfer = `req_valid[grant_id]` && `req_ready[grant_id]`.
  - On a transfer: `fifo_wr_en` = 1, `fifo_wr_data` = `req_data[grant_id]`, `beat_cnt` increments.
  - No transfer means `fifo_wr_en` = 0 and `fifo_wr_data` = 0.
- Leave GRANT (to IDLE, `last_id` <= `grant_id`) when either:
  - a transfer occurs with `beat_cnt` == MAX_BURST-1, or
  - `req_valid[grant_id]` == 0 (no transfer that cycle).
- `fifo_full` stall: the grant is held and `beat_cnt` is frozen. Full never causes rotation.
- Requesters must hold `req_valid` and `req_data` stable until accepted.
- A requester whose burst ends competes again only after all other valid requesters have been scanned.
- Non-granted requesters are never ready; there are no writes while in IDLE.
- The FIFO therefore never sees `wr_en` while `full` is high. No beat is dropped or duplicated.

## Timing
- Arbitration latency: 1 cycle. Valid seen in IDLE at edge t gives `req_ready` high after edge t, and the first beat is written at edge t+1.
- Burst throughput: 1 beat/cycle while `fifo_full` = 0.
- Rotation cost: 1 idle cycle between grants (the IDLE cycle).
- With all N requesters continuously valid and the FIFO never full:
  - Pattern per requester: MAX_BURST writes, then 1 bubble.
  - Grant order: 0,1,…,N-1,0,…
- `fifo_full` is sampled combinationally in the same cycle as `fifo_wr_en`. This matches the FIFO's same-cycle `full` qualification.
- Simultaneous events:
  - A final-beat transfer and the holder dropping `req_valid` afterwards need nothing extra: the FSM is already going to IDLE.
  - A `fifo_full` rise during the final beat stalls it; exit happens on the eventual transfer.
- Reset mid-burst: all state is cleared asynchronously and `req_ready` drops immediately. The partial burst is abandoned; beats already written stay in the FIFO.

## Test plan
- **Single requester:** reset; `req_valid[2]`=1 with data 0x10..0x15, FIFO empty.
  - Expect `grant_id`=2.
  - Writes 0x10..0x13 on 4 consecutive edges, 1 IDLE bubble, then 0x14,0x15.
  - FIFO count=6; reading returns 0x10..0x15 in order.
- **All four requesters valid continuously:** requester k sends 0xk0,0xk1,…
  - Grant sequence 0,1,2,3,0.
  - FIFO holds 0x00-0x03, 0x10-0x13, 0x20-0x23, 0x30-0x33 in that order.
  - Exactly one `fifo_wr_en`=0 cycle between bursts.
- **Back-pressure:** FIFO pre-filled to 15; requester 1 holds 3 beats (0xA0..0xA2).
  - 0xA0 is written and `full` rises.
  - `req_ready[1]`=0 and `fifo_wr_en`=0 for 5 cycles; `grant_id` stays 1.
  - Read 2 entries, then 0xA1,0xA2 are written with no loss or duplicate.
- **Early release:** requester 0 sends 2 beats, then drops `req_valid` while requester 3 is valid.
  - Grant returns to IDLE after the second beat and the drop.
  - Next grant is 3, not 0.
- **Reset mid-burst:** assert `rst_n`=0 after the 2nd beat of requester 2.
  - `req_ready`=0, `fifo_wr_en`=0 and `busy`=0 immediately.
  - After release, first grant goes to the lowest valid index starting from 0.
- **Idle:** no `req_valid` for 20 cycles → `busy`=0, `fifo_wr_en`=0, `grant_id` unchanged.
